// File: rtl/l2_line_cache.sv
// Direct-mapped, write-back, write-allocate L2 between the L1 data cache and main memory.
// Whole 128-bit lines move on both sides, so a write miss installs without fetching.
module l2_line_cache #(
  parameter int SET_BITS = 6
) (
  input  logic         clk,
  input  logic         proc_reset,
  input  logic         l1_read,
  input  logic         l1_write,
  input  logic [27:0]  l1_addr,
  input  logic [127:0] l1_wdata,
  output logic         l1_ready,
  output logic [127:0] l1_rdata,
  output logic         mem_read,
  output logic         mem_write,
  output logic [27:0]  mem_addr,
  output logic [127:0] mem_wdata,
  input  logic [127:0] mem_rdata,
  input  logic         mem_ready
);

  localparam int NUM_SETS = 1 << SET_BITS;
  localparam int TAG_W    = 28 - SET_BITS;

  typedef enum logic [2:0] {
    S_IDLE, S_LOOKUP, S_WB, S_FILL, S_RESP, S_HOLD
  } state_e;

  state_e              state_q;
  logic [27:0]         addr_q;
  logic [127:0]        wdata_q;
  logic                op_write_q;
  logic                l1_ready_q;
  logic [127:0]        l1_rdata_q;
  logic                mem_read_q;
  logic                mem_write_q;
  logic [27:0]         mem_addr_q;
  logic [127:0]        mem_wdata_q;
  logic [NUM_SETS-1:0] valid_q;
  logic [NUM_SETS-1:0] dirty_q;

  logic [TAG_W-1:0]    tag_mem  [NUM_SETS];
  logic [127:0]        data_mem [NUM_SETS];

  logic [SET_BITS-1:0] idx;
  logic [TAG_W-1:0]    tag;
  logic                hit;
  logic                victim_dirty;
  logic                inst_en;
  logic                inst_dirty;
  logic [127:0]        inst_data;

  assign idx          = addr_q[SET_BITS-1:0];
  assign tag          = addr_q[27:SET_BITS];
  assign hit          = valid_q[idx] && (tag_mem[idx] == tag);
  assign victim_dirty = valid_q[idx] && dirty_q[idx];

  // One install port serves write hits, write allocation and line fills.
  always_comb begin
    inst_en    = 1'b0;
    inst_data  = wdata_q;
    inst_dirty = 1'b1;
    case (state_q)
      S_LOOKUP: inst_en = op_write_q && (hit || !victim_dirty);
      S_WB:     inst_en = mem_ready && op_write_q;
      S_FILL: begin
        inst_en    = mem_ready;
        inst_data  = mem_rdata;
        inst_dirty = 1'b0;
      end
      default: ;
    endcase
  end

  // NOTE: tag/data arrays carry no reset; valid_q alone decides whether an entry is meaningful.
  always_ff @(posedge clk) begin
    if (inst_en) begin
      tag_mem[idx]  <= tag;
      data_mem[idx] <= inst_data;
    end
  end

  always_ff @(posedge clk or posedge proc_reset) begin
    if (proc_reset) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      op_write_q  <= 1'b0;
      l1_ready_q  <= 1'b0;
      l1_rdata_q  <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      valid_q     <= '0;
      dirty_q     <= '0;
    end else begin
      l1_ready_q <= 1'b0;
      if (inst_en) begin
        valid_q[idx] <= 1'b1;
        dirty_q[idx] <= inst_dirty;
      end
      case (state_q)
        S_IDLE: begin
          if (l1_read || l1_write) begin
            addr_q     <= l1_addr;
            wdata_q    <= l1_wdata;
            op_write_q <= l1_write;
            state_q    <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          if (hit) begin
            if (!op_write_q) l1_rdata_q <= data_mem[idx];
            l1_ready_q <= 1'b1;
            state_q    <= S_RESP;
          end else if (victim_dirty) begin
            mem_write_q <= 1'b1;
            mem_addr_q  <= {tag_mem[idx], idx};
            mem_wdata_q <= data_mem[idx];
            state_q     <= S_WB;
          end else if (!op_write_q) begin
            mem_read_q <= 1'b1;
            mem_addr_q <= addr_q;
            state_q    <= S_FILL;
          end else begin
            l1_ready_q <= 1'b1;
            state_q    <= S_RESP;
          end
        end
        S_WB: begin
          if (mem_ready) begin
            mem_write_q <= 1'b0;
            if (op_write_q) begin
              l1_ready_q <= 1'b1;
              state_q    <= S_RESP;
            end else begin
              mem_read_q <= 1'b1;
              mem_addr_q <= addr_q;
              state_q    <= S_FILL;
            end
          end
        end
        S_FILL: begin
          if (mem_ready) begin
            mem_read_q <= 1'b0;
            l1_rdata_q <= mem_rdata;
            l1_ready_q <= 1'b1;
            state_q    <= S_RESP;
          end
        end
        S_RESP:  state_q <= S_HOLD;
        // L1 still shows the request it just had answered, so this cycle ignores it.
        S_HOLD:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign l1_ready  = l1_ready_q;
  assign l1_rdata  = l1_rdata_q;
  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_l2_line_cache.sv
// Bench for l2_line_cache: directed scenarios then random traffic against a set-level cache model,
// with a memory responder that answers 3 cycles after each request.
module tb_l2_line_cache;

  localparam int SB = 6;
  localparam int NS = 1 << SB;
  localparam logic [127:0] LINE_A5 = 128'hA5A5_A5A5_A5A5_A5A5_A5A5_A5A5_A5A5_A501;
  localparam logic [127:0] LINE_12 = 128'h1234_5678_9ABC_DEF0_1234_5678_9ABC_DEF9;

  typedef struct {
    bit           wr;
    logic [27:0]  addr;
    logic [127:0] data;
  } mem_op_t;

  logic         clk = 1'b0;
  logic         proc_reset;
  logic         l1_read, l1_write;
  logic [27:0]  l1_addr;
  logic [127:0] l1_wdata;
  logic         l1_ready;
  logic [127:0] l1_rdata;
  logic         mem_read, mem_write;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata;
  logic         mem_ready;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int last_ready_cyc = 0;
  int cnt = 0;
  bit prev_rd = 1'b0, prev_wr = 1'b0;

  logic [127:0] env_mem [logic [27:0]];
  logic [127:0] ref_mem [logic [27:0]];
  mem_op_t act_q[$];
  mem_op_t exp_q[$];

  bit            mv [NS];
  bit            md [NS];
  logic [27-SB:0] mt [NS];
  logic [127:0]  mdat [NS];
  logic [127:0]  last_rd = '0;

  l2_line_cache #(.SET_BITS(SB)) dut (
    .clk(clk), .proc_reset(proc_reset),
    .l1_read(l1_read), .l1_write(l1_write), .l1_addr(l1_addr), .l1_wdata(l1_wdata),
    .l1_ready(l1_ready), .l1_rdata(l1_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [127:0] default_line(input logic [27:0] a);
    return {a, 4'h3, ~a, 4'h5, a ^ 28'h5A5A5A5, 4'hC, 32'hC0FFEE00 ^ {4'h0, a}};
  endfunction

  function automatic logic [127:0] env_line(input logic [27:0] a);
    return env_mem.exists(a) ? env_mem[a] : default_line(a);
  endfunction

  function automatic logic [127:0] ref_line(input logic [27:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : default_line(a);
  endfunction

  // Memory responder: ready pulse on the third cycle a request is seen.
  always @(negedge clk) begin
    if (proc_reset) begin
      cnt = 0;
      mem_ready = 1'b0;
    end else if (mem_ready) begin
      mem_ready = 1'b0;
    end else if (mem_read || mem_write) begin
      cnt++;
      if (cnt == 3) begin
        cnt = 0;
        if (mem_write) env_mem[mem_addr] = mem_wdata;
        else mem_rdata = env_line(mem_addr);
        mem_ready = 1'b1;
        last_ready_cyc = cyc;
      end
    end else begin
      cnt = 0;
    end
  end

  // Log each memory request as it starts; flag any overlap of read and write.
  always @(negedge clk) begin
    if (mem_read && mem_write) check("rd_wr_overlap", 1'b1, 1'b0);
    if (mem_read && !prev_rd) act_q.push_back('{1'b0, mem_addr, '0});
    if (mem_write && !prev_wr) act_q.push_back('{1'b1, mem_addr, mem_wdata});
    prev_rd = mem_read;
    prev_wr = mem_write;
  end

  task automatic model_reset();
    for (int s = 0; s < NS; s++) begin
      mv[s] = 1'b0;
      md[s] = 1'b0;
    end
    last_rd = '0;
  endtask

  task automatic do_op(input bit wr, input logic [27:0] a, input logic [127:0] wd, input bit hold);
    int            s;
    logic [27-SB:0] t;
    logic [127:0]  exp_data;
    logic [27:0]   vaddr;
    bit            got;
    int            start;
    s = int'(a[SB-1:0]);
    t = a[27:SB];
    exp_q.delete();
    exp_data = '0;
    if (mv[s] && mt[s] == t) begin
      if (wr) begin
        mdat[s] = wd;
        md[s]   = 1'b1;
      end else begin
        exp_data = mdat[s];
      end
    end else begin
      if (mv[s] && md[s]) begin
        vaddr = {mt[s], a[SB-1:0]};
        exp_q.push_back('{1'b1, vaddr, mdat[s]});
        ref_mem[vaddr] = mdat[s];
      end
      if (wr) begin
        mdat[s] = wd;
        md[s]   = 1'b1;
      end else begin
        exp_q.push_back('{1'b0, a, '0});
        exp_data = ref_line(a);
        mdat[s]  = exp_data;
        md[s]    = 1'b0;
      end
      mv[s] = 1'b1;
      mt[s] = t;
    end

    act_q.delete();
    @(negedge clk);
    l1_read  = !wr;
    l1_write = wr;
    l1_addr  = a;
    l1_wdata = wd;
    start    = cyc;
    got      = 1'b0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      if (l1_ready) got = 1'b1;
    end
    if (!got) begin
      check("ready_timeout", 1'b0, 1'b1);
    end else begin
      if (exp_q.size() == 0) check("lat_no_mem", cyc, start + 2);
      else check("lat_after_mem", cyc, last_ready_cyc + 1);
      if (!wr) begin
        check("rdata", l1_rdata, exp_data);
        last_rd = exp_data;
      end else begin
        check("rdata_kept_on_write", l1_rdata, last_rd);
      end
    end
    if (!hold) begin
      l1_read  = 1'b0;
      l1_write = 1'b0;
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (k == 0) begin
        l1_read  = 1'b0;
        l1_write = 1'b0;
      end
      check("no_extra_ready", l1_ready, 1'b0);
      if (k < 2) check("rdata_stable", l1_rdata, last_rd);
    end
    check("mem_op_count", act_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < act_q.size(); i++) begin
      check("mem_op_kind", act_q[i].wr, exp_q[i].wr);
      check("mem_op_addr", act_q[i].addr, exp_q[i].addr);
      if (exp_q[i].wr) check("mem_op_wdata", act_q[i].data, exp_q[i].data);
    end
  endtask

  initial begin
    bit got;
    proc_reset = 1'b1;
    l1_read = 1'b0;
    l1_write = 1'b0;
    l1_addr = '0;
    l1_wdata = '0;
    mem_rdata = '0;
    mem_ready = 1'b0;
    env_mem[28'h0000010] = LINE_A5;
    ref_mem[28'h0000010] = LINE_A5;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_l1_ready", l1_ready, 1'b0);
    check("rst_mem_read", mem_read, 1'b0);
    check("rst_mem_write", mem_write, 1'b0);
    check("rst_l1_rdata", l1_rdata, '0);
    check("rst_mem_addr", mem_addr, '0);
    check("rst_mem_wdata", mem_wdata, '0);
    proc_reset = 1'b0;
    @(negedge clk);

    do_op(1'b0, 28'h0000010, '0, 1'b0);        // cold read miss
    check("t1_data", l1_rdata, LINE_A5);
    do_op(1'b0, 28'h0000010, '0, 1'b0);        // read hit
    check("t2_data", l1_rdata, LINE_A5);
    do_op(1'b1, 28'h0000010, LINE_12, 1'b0);   // write hit
    do_op(1'b0, 28'h0000010, '0, 1'b0);
    check("t3_data", l1_rdata, LINE_12);
    do_op(1'b0, 28'h0000050, '0, 1'b0);        // dirty-victim read miss
    do_op(1'b0, 28'h0000050, '0, 1'b1);        // request held past l1_ready
    do_op(1'b1, 28'h0000123, {4{32'hFEEDF00D}}, 1'b0);  // clean write miss

    // Reset while a fill is in flight.
    act_q.delete();
    @(negedge clk);
    l1_read = 1'b1;
    l1_addr = 28'h0000090;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (mem_read) got = 1'b1;
    end
    check("t6_fill_started", got, 1'b1);
    #2 proc_reset = 1'b1;
    l1_read = 1'b0;
    #1 check("t6_mem_read_dropped", mem_read, 1'b0);
    check("t6_ready_low", l1_ready, 1'b0);
    model_reset();
    @(negedge clk);
    proc_reset = 1'b0;
    @(negedge clk);
    do_op(1'b0, 28'h0000090, '0, 1'b0);
    do_op(1'b0, 28'h0000010, '0, 1'b0);

    for (int n = 0; n < 120; n++) begin
      logic [27:0] a;
      a = {22'($urandom_range(0, 3)), 6'($urandom_range(0, 7))};
      do_op(1'($urandom_range(0, 1)), a, {$urandom, $urandom, $urandom, $urandom},
            $urandom_range(0, 3) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
